// File: rtl/alt_link_pkg.sv
// Shared definitions for the single-wire altitude link.
// Used by both the transmitter and the autopilot-side receiver.
package alt_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } alt_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    localparam int DEFAULT_DATA_W = 10;

endpackage

// File: rtl/alt_baud_tick.sv
// Baud counter for the altitude link: strobes on the last
// clock of every serial bit, held at zero while restart is high.
module alt_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST) && !restart;

    always_ff @(posedge clock) begin
        if (reset || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/altimetre_tx.sv
// Bit-serial altitude-frame transmitter: start, data LSB first,
// optional even parity, stop. One sample of buffering.
module altimetre_tx
    import alt_link_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_data_i,
    output logic              sample_ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    alt_state_t        state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DATA_W-1:0] hold, hold_n;
    logic              hold_full, hold_full_n;
    logic              par, par_n;
    logic [BW-1:0]     bit_idx, bit_idx_n;
    logic              tx_d;
    logic              bit_end;
    logic              frame_end;
    logic              accept;

    alt_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .restart(state == IDLE),
        .tick   (bit_end)
    );

    assign sample_ready_o = !hold_full;
    assign accept         = sample_valid_i && !hold_full;
    assign frame_end      = (state == STOP) && bit_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            par         <= 1'b0;
            bit_idx     <= '0;
            tx_o        <= IDLE_LVL;
            frame_cnt_o <= '0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            par       <= par_n;
            bit_idx   <= bit_idx_n;
            tx_o      <= tx_d;
            if (frame_end) begin
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        par_n       = par;
        bit_idx_n   = bit_idx;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shift_n = sample_data_i;
                    par_n   = ^sample_data_i;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_idx == LAST_BIT) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // pending sample wins; a fresh one may bypass hold
                    if (hold_full) begin
                        state_n     = START;
                        shift_n     = hold;
                        par_n       = ^hold;
                        hold_full_n = 1'b0;
                    end else if (accept) begin
                        state_n = START;
                        shift_n = sample_data_i;
                        par_n   = ^sample_data_i;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (accept && state != IDLE && !frame_end) begin
            hold_n      = sample_data_i;
            hold_full_n = 1'b1;
        end
    end

    always_comb begin
        tx_d = IDLE_LVL;
        unique case (state_n)
            IDLE:    tx_d = IDLE_LVL;
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_n[0];
            PARITY:  tx_d = par_n;
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    assign busy_o = (state != IDLE);
    assign done_o = frame_end;

endmodule

// File: tb/tb_altimetre_tx.sv
// Directed bench for altimetre_tx: parity and no-parity instances,
// CLKS_PER_BIT=4; the wrap test uses a narrow frame counter.
module tb_altimetre_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_valid = 1'b0;
    logic [9:0]  a_data = '0;
    logic        a_ready, a_tx, a_busy, a_done;
    logic [15:0] a_cnt;

    logic        b_valid = 1'b0;
    logic [9:0]  b_data = '0;
    logic        b_ready, b_tx, b_busy, b_done;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    altimetre_tx #(
        .DATA_W(10), .CLKS_PER_BIT(4), .PARITY_EN(1), .CNT_W(16)
    ) dut_a (
        .clock(clk), .reset(reset),
        .sample_valid_i(a_valid), .sample_data_i(a_data),
        .sample_ready_o(a_ready), .tx_o(a_tx),
        .busy_o(a_busy), .done_o(a_done), .frame_cnt_o(a_cnt)
    );

    altimetre_tx #(
        .DATA_W(10), .CLKS_PER_BIT(4), .PARITY_EN(0), .CNT_W(4)
    ) dut_b (
        .clock(clk), .reset(reset),
        .sample_valid_i(b_valid), .sample_data_i(b_data),
        .sample_ready_o(b_ready), .tx_o(b_tx),
        .busy_o(b_busy), .done_o(b_done), .frame_cnt_o(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // expected line level for bit slot i of a frame carrying d
    function automatic logic fbit(input logic [9:0] d, input bit pe,
                                  input int i);
        if (i == 0) return 1'b0;
        if (i <= 10) return d[i-1];
        if (i == 11 && pe) return ^d;
        return 1'b1;
    endfunction

    logic [9:0] seq [3];
    int acc, dones, gaps, bad;
    bit finished;

    initial begin
        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst tx", a_tx, 1);
        check("rst busy", a_busy, 0);
        check("rst ready", a_ready, 1);
        check("rst cnt", a_cnt, 0);
        check("rst done", a_done, 0);
        check("rst b cnt", b_cnt, 0);

        // 2: single frame 2A5, bits 0,1,0,1,0,0,1,0,1,0,1,1,1
        a_valid = 1'b1;
        a_data  = 10'h2A5;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            if (k <= 52) begin
                check($sformatf("f1 tx k=%0d", k), a_tx,
                      fbit(10'h2A5, 1, (k - 1) / 4));
                check($sformatf("f1 done k=%0d", k), a_done, k == 52);
            end else begin
                check("f1 idle busy", a_busy, 0);
                check("f1 idle tx", a_tx, 1);
                check("f1 cnt", a_cnt, 1);
            end
        end
        if (a_data != 10'h2A5) $display("note: data changed");

        // 3+4: three samples, third held off while hold is full
        seq[0] = 10'h000;
        seq[1] = 10'h3FF;
        seq[2] = 10'h155;
        a_valid = 1'b1;
        a_data  = seq[0];
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k <= 156) begin
                check($sformatf("f3 tx k=%0d", k), a_tx,
                      fbit(seq[(k - 1) / 52], 1, ((k - 1) % 52) / 4));
                check($sformatf("f3 done k=%0d", k), a_done,
                      (k % 52) == 0);
            end else begin
                check($sformatf("f3 idle tx k=%0d", k), a_tx, 1);
                check($sformatf("f3 idle busy k=%0d", k), a_busy, 0);
            end
            if (k == 1) a_valid = 1'b0;
            if (k == 2) begin
                a_valid = 1'b1;
                a_data  = seq[1];
            end
            if (k == 3) begin
                check("f3 ready low", a_ready, 0);
                a_data = seq[2];
            end
            if (k == 52) check("f3 ready still low", a_ready, 0);
            if (k == 53) check("f3 ready reopens", a_ready, 1);
            if (k == 54) begin
                check("f3 third held", a_ready, 0);
                a_valid = 1'b0;
                a_data  = 10'h0AA;
            end
            if (k == 105) check("f3 cnt two", a_cnt, 3);
        end
        check("f3 cnt final", a_cnt, 4);

        // 5: reset during 6th data bit, with a sample pending in hold
        a_valid = 1'b1;
        a_data  = 10'h155;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (k == 1) a_data = 10'h0AA;
            if (k == 2) begin
                check("f5 hold full", a_ready, 0);
                a_valid = 1'b0;
            end
            if (k == 26) begin
                check("f5 tx bit5", a_tx, fbit(10'h155, 1, 6));
                reset = 1'b1;
            end
            if (k == 27) begin
                check("f5 tx", a_tx, 1);
                check("f5 busy", a_busy, 0);
                check("f5 ready", a_ready, 1);
                check("f5 cnt", a_cnt, 0);
                check("f5 done", a_done, 0);
                reset = 1'b0;
            end
        end
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) bad++;
        end
        check("f5 stays idle", bad, 0);
        check("f5 cnt after", a_cnt, 0);

        // 6: no-parity frame of 48 cycles
        b_valid = 1'b1;
        b_data  = 10'h001;
        for (int k = 1; k <= 49; k++) begin
            @(negedge clk);
            if (k == 1) b_valid = 1'b0;
            if (k <= 48) begin
                check($sformatf("f6 tx k=%0d", k), b_tx,
                      fbit(10'h001, 0, (k - 1) / 4));
                check($sformatf("f6 done k=%0d", k), b_done, k == 48);
            end else begin
                check("f6 idle busy", b_busy, 0);
                check("f6 cnt", b_cnt, 1);
            end
        end

        // 6b: 15 more back-to-back frames wrap the 4-bit counter
        b_valid  = 1'b1;
        b_data   = 10'h2C3;
        acc      = 1;
        dones    = 0;
        gaps     = 0;
        finished = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (b_done) dones++;
            if (!b_busy) begin
                if (dones >= 15) begin
                    finished = 1'b1;
                    break;
                end
                gaps++;
            end
            if (acc == 15) b_valid = 1'b0;
            else if (b_valid && b_ready) acc++;
        end
        check("f6 finished in budget", finished, 1);
        check("f6 dones", dones, 15);
        check("f6 accepts", acc, 15);
        check("f6 no gaps", gaps, 0);
        check("f6 cnt wrap", b_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
